// File: rtl/sr_cmd_pkg.sv
// Shared types and helpers for the SR flop-bank command driver.
// Excitation codes map bit 1 to set and bit 0 to reset.
package sr_cmd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [1:0] EXC_HOLD    = 2'b00;
  localparam logic [1:0] EXC_RESET   = 2'b01;
  localparam logic [1:0] EXC_SET     = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL = 2'b11;

  function automatic int nchunk(input int w, input int c);
    return w / c;
  endfunction

  // Never yields EXC_ILLEGAL: set and reset are mutually exclusive.
  function automatic logic [1:0] excite(
    input logic tgt,
    input logic shd,
    input logic en
  );
    if (!en || (tgt == shd)) return EXC_HOLD;
    return tgt ? EXC_SET : EXC_RESET;
  endfunction

endpackage

// File: rtl/sr_excite.sv
// Combinational per-bit SR excitation: set, reset or hold.
// Bits outside the enable mask always hold.
module sr_excite
  import sr_cmd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] shd_i,
  input  logic [WIDTH-1:0] en_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] code;
    assign code   = excite(tgt_i[i], shd_i[i], en_i[i]);
    assign s_o[i] = code[1];
    assign r_o[i] = code[0];
  end

endmodule

// File: rtl/sr_cmd_driver.sv
// Chunked set/reset command driver for a bank of SR flops.
// Define READBACK_CHECK_EN to compare q_in with the shadow on completion.
module sr_cmd_driver
  import sr_cmd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err
);

  localparam int NCH = nchunk(WIDTH, CHUNK);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(SETTLE_CYC + 1);

  state_t           state_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] shd_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] en;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] shd_d;
  logic             mism;

  always_comb begin
    en = '0;
    for (int i = 0; i < WIDTH; i++) begin
      en[i] = (idx_q == IW'(i / CHUNK));
    end
  end

  sr_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .tgt_i(tgt_q),
    .shd_i(shd_q),
    .en_i (en),
    .s_o  (s_d),
    .r_o  (r_d)
  );

  assign shd_d = (shd_q & ~en) | (tgt_q & en);

`ifdef READBACK_CHECK_EN
  assign mism = (q_in != shd_q);
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign mism        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      tgt_q   <= '0;
      shd_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      s_q    <= '0;
      r_q    <= '0;
      case (state_q)
        ST_INIT: begin
          r_q     <= '1;
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          // Ready is raised one cycle after entering IDLE.
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (tgt_valid) begin
            tgt_q   <= tgt_data;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          s_q   <= s_d;
          r_q   <= r_d;
          shd_q <= shd_d;
          if (idx_q == IW'(NCH - 1)) begin
            cnt_q   <= CW'(SETTLE_CYC);
            state_q <= ST_SETTLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(1)) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          if (mism) err_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign tgt_ready = ready_q;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Randomized self-checking bench for sr_cmd_driver.
// Reference model tracks the flop bank as a plain bit vector.
module tb_sr_cmd_driver;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int ST  = 2;
  localparam int NCH = W / CH;
`ifdef READBACK_CHECK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tgt_valid = 1'b0;
  logic         tgt_ready;
  logic [W-1:0] tgt_data = '0;
  logic [W-1:0] s_out;
  logic [W-1:0] r_out;
  logic [W-1:0] q_in;
  logic         done;
  logic         err;

  logic [W-1:0] bank = '0;
  logic         force_q0 = 1'b0;

  logic [W-1:0] sh_m = '0;
  logic         err_m = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  sr_cmd_driver #(
    .WIDTH(W),
    .CHUNK(CH),
    .SETTLE_CYC(ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_data (tgt_data),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bank <= (bank & ~r_out) | s_out;

  assign q_in = force_q0 ? '0 : bank;

  task automatic test_reset();
    #2;
    n_checks++;
    if (tgt_ready !== 1'b0 || s_out !== '0 || r_out !== '0 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: rdy=%b s=%h r=%h done=%b err=%b want 0",
               tgt_ready, s_out, r_out, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (r_out !== 8'hFF || tgt_ready !== 1'b0 || s_out !== '0) begin
      n_fail++;
      $display("FAIL init_cycle: r=%h rdy=%b s=%h want r=ff rdy=0 s=00",
               r_out, tgt_ready, s_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (r_out !== '0 || tgt_ready !== 1'b1 || s_out !== '0) begin
      n_fail++;
      $display("FAIL idle_after_init: r=%h rdy=%b s=%h want r=00 rdy=1 s=00",
               r_out, tgt_ready, s_out);
    end
    sh_m  = '0;
    err_m = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] t, input bit hold, input string nm);
    int w;
    logic [W-1:0] mask, es, er;
    bit de, re;
    w = 0;
    while (tgt_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (tgt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_wait: rdy=%b want 1", nm, tgt_ready);
      return;
    end
    tgt_valid = 1'b1;
    tgt_data  = t;
    @(posedge clk); #1;
    if (hold) tgt_data = W'($urandom);
    else tgt_valid = 1'b0;
    n_checks++;
    if (tgt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: rdy=%b want 0", nm, tgt_ready);
    end
    for (int c = 1; c <= NCH + ST + 2; c++) begin
      @(posedge clk); #1;
      es = '0;
      er = '0;
      if (c <= NCH) begin
        mask = W'(((1 << CH) - 1) << ((c - 1) * CH));
        es   = t & ~sh_m & mask;
        er   = ~t & sh_m & mask;
        sh_m = (sh_m & ~mask) | (t & mask);
      end
      de = (c == NCH + ST + 1);
      re = (c == NCH + ST + 2);
      if (de && RB) err_m = err_m | ((force_q0 ? '0 : sh_m) != sh_m);
      if (hold && c == NCH + ST + 2) tgt_valid = 1'b0;
      n_checks++;
      if (s_out !== es || r_out !== er) begin
        n_fail++;
        $display("FAIL %s_cmd c%0d: s=%h r=%h want s=%h r=%h",
                 nm, c, s_out, r_out, es, er);
      end
      n_checks++;
      if ((s_out & r_out) !== '0) begin
        n_fail++;
        $display("FAIL %s_sr_excl c%0d: s&r=%h want 00", nm, c, s_out & r_out);
      end
      n_checks++;
      if (done !== de || tgt_ready !== re) begin
        n_fail++;
        $display("FAIL %s_hs c%0d: done=%b rdy=%b want done=%b rdy=%b",
                 nm, c, done, tgt_ready, de, re);
      end
      n_checks++;
      if (err !== err_m) begin
        n_fail++;
        $display("FAIL %s_err c%0d: err=%b want %b", nm, c, err, err_m);
      end
    end
  endtask

  task automatic test_directed();
    send(8'hA5, 1'b0, "a5");
    send(8'h5A, 1'b0, "5a");
    send(8'h5A, 1'b1, "5a_again_hold");
  endtask

  task automatic test_readback();
    force_q0 = 1'b1;
    send(8'h0F, 1'b0, "rb_bad");
    force_q0 = 1'b0;
    send(8'hF0, 1'b0, "rb_good");
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 24; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        tgt_data = W'($urandom);
        @(posedge clk); #1;
      end
      send(W'($urandom), 1'($urandom), "rnd");
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    int w;
    w = 0;
    while (tgt_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tgt_valid = 1'b1;
    tgt_data  = ~sh_m;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ((s_out | r_out) !== 8'h0F) begin
      n_fail++;
      $display("FAIL mid_chunk0: s|r=%h want 0f", s_out | r_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_out !== '0 || r_out !== '0 || tgt_ready !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: s=%h r=%h rdy=%b done=%b err=%b want 0",
               s_out, r_out, tgt_ready, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sh_m  = '0;
    err_m = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (r_out !== 8'hFF || tgt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit: r=%h rdy=%b want r=ff rdy=0", r_out, tgt_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || tgt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_target: done_seen=%b rdy=%b want 0 and 1",
               seen, tgt_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_readback();
    test_random();
    test_mid_reset();
    send(8'h3C, 1'b0, "post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
Command-side driver for a bank of SR storage flops. It accepts a target word over a valid/ready handshake and computes per-bit excitation: set, reset or hold, never the illegal S=R=1 pair. It issues the commands chunk by chunk, waits a settle window, then signals completion. A shadow register tracks what the flop bank holds, so only changing bits receive set/reset pulses.

Parameters:
WIDTH, 8, number of SR flops driven.
CHUNK, 4, bits commanded per drive cycle; WIDTH must be a multiple of CHUNK.
SETTLE_CYC, 2, idle cycles after the last chunk before completion; must be >= 1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
tgt_valid  input  1  target word valid.
tgt_ready  output  1  driver can accept a target.
tgt_data  input  WIDTH  desired flop-bank contents.
s_out  output  WIDTH  per-bit set command to flop bank.
r_out  output  WIDTH  per-bit reset command to flop bank.
q_in  input  WIDTH  readback of flop-bank outputs.
done  output  1  one-cycle pulse when an update completes.
err  output  1  sticky readback mismatch flag.

Behaviour:
- One clock (clk). Asynchronous active-low reset (rst_n). All outputs are registered.
- While rst_n=0: state=INIT, tgt_ready=0, s_out=0, r_out=0, done=0, err=0, shadow=0, chunk index=0.
- Reset asserted mid-operation clears everything immediately. Any in-flight target is dropped.
- Invariant every cycle: (s_out & r_out) == 0.
- States: INIT, IDLE, DRIVE, SETTLE, DONE.
- INIT: lasts exactly 1 cycle after reset release.
  - r_out = all ones, forcing the bank to 0 so it matches shadow=0.
  - Next state: IDLE.
- IDLE:
  - tgt_ready=1, s_out=r_out=0.
  - On tgt_valid & tgt_ready: latch tgt_data into target, set chunk index=0, tgt_ready=0 next cycle, go to DRIVE.
- DRIVE: one cycle per chunk, NCHUNK = WIDTH/CHUNK cycles total.
  - Bits in the active chunk k: s = target & ~shadow, r = ~target & shadow.
  - All bits outside chunk k: s = r = 0.
  - Shadow is updated for chunk k in the same cycle.
  - After chunk NCHUNK-1, go to SETTLE.
- An unchanged chunk still consumes its cycle with all-zero commands. A target equal to shadow therefore runs the full sequence with no pulses.
- SETTLE: SETTLE_CYC cycles, s_out=r_out=0, counter counts down. Then go to DONE.
- DONE: 1 cycle, done=1, tgt_ready=0. Next state: IDLE.
- Latency: handshake accepted on edge E0.
  - Chunk k commands are visible after edge E0+1+k.
  - done is visible after edge E0+NCHUNK+SETTLE_CYC+1.
  - tgt_ready rises one cycle after done.
- tgt_valid while busy: ignored (ready=0). The upstream must hold data until accepted. tgt_data changing while not ready has no effect.
- Width rule: the chunk index is $clog2(NCHUNK) bits, minimum 1. It never wraps past NCHUNK-1.
- shadow is internal only, with no output port.

Optional Feature:
Macro READBACK_CHECK_EN.
- Defined: in the DONE cycle, q_in is compared with shadow. On any mismatch, err is set to 1 and stays set until rst_n.
- Undefined: q_in is unused and err is tied to 0. The port list is unchanged.

Decomposition:
- Package sr_cmd_pkg holds:
  - state enum (INIT, IDLE, DRIVE, SETTLE, DONE);
  - localparam helper for NCHUNK;
  - constant for the excitation encoding: HOLD=2'b00, RESET=2'b01, SET=2'b10, ILLEGAL=2'b11.
- One sub-module, sr_excite: pure combinational per-bit excitation (target, shadow, enable -> s, r). It is instantiated WIDTH times or as a vector.

Test Plan:
- Reset release, WIDTH=8, CHUNK=4 -> one cycle with r_out=8'hFF and tgt_ready=0, then tgt_ready=1 with s_out=r_out=0.
- From shadow 8'h00, send target 8'hA5 ->
  - cycle 1: s_out=8'h05;
  - cycle 2: s_out=8'hA0;
  - r_out=0 throughout;
  - done pulses 2+2+1 cycles after acceptance.
- Then send target 8'h5A ->
  - cycle 1: s=8'h0A, r=8'h05;
  - cycle 2: s=8'h50, r=8'hA0;
  - s&r==0 checked every cycle.
- Re-send 8'h5A -> all commands zero and done still pulses at the same latency. tgt_valid held high during busy is ignored, with no second accept.
- rst_n pulsed low during DRIVE chunk 0 -> outputs clear asynchronously, INIT repeats, and done never pulses for the dropped target.
- With READBACK_CHECK_EN, q_in forced to 8'h00 during target 8'h0F -> err=1 after DONE and stays 1 through the next good update until reset. Without the macro, err stays 0.
